// File: rtl/skin_pkg.sv
// Shared definitions for the skin / background-difference frame sequencer:
// state encoding, default frame geometry and frame size derivation.
package skin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIN    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_COMPARE = 2'd3
  } seq_state_t;

  localparam int DEF_FRAME_W = 160;
  localparam int DEF_FRAME_H = 120;
  localparam int DEF_ADDR_W  = 15;
  localparam int DEF_RD_LAT  = 1;

  function automatic int frame_pixels(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/skin_frame_sequencer_pix_addr_counter.sv
// Saturating per-frame pixel counter. The sof pixel is address 0; the count
// saturates at FRAME_PIXELS so overflow stays asserted until the next sof.
module pix_addr_counter #(
  parameter int ADDR_W       = 15,
  parameter int FRAME_PIXELS = 19200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              sof_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o,
  output logic              overflow_o
);

  // One extra bit so the saturated value FRAME_PIXELS is representable even
  // when FRAME_PIXELS == 2**ADDR_W.
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] FP_C   = CW'(FRAME_PIXELS);
  localparam logic [CW-1:0] LAST_C = CW'(FRAME_PIXELS - 1);

  logic [CW-1:0] cnt_q, cnt_d, cur_idx;

  always_comb begin
    cur_idx = sof_i ? '0 : cnt_q;
    cnt_d   = cnt_q;
    if (en_i) begin
      if (sof_i) begin
        cnt_d = CW'(1);
      end else if (cnt_q < FP_C) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign addr_o     = cur_idx[ADDR_W-1:0];
  assign last_o     = (cur_idx == LAST_C);
  assign overflow_o = (cur_idx >= FP_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/skin_frame_sequencer.sv
// Frame-level sequencer: schedules background-capture / compare / skin frames
// and drives the background luma RAM strobes and the decider mode select.
module skin_frame_sequencer
  import skin_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int FRAME_H = DEF_FRAME_H,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int RD_LAT  = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid_i,
  input  logic              pix_sof_i,
  input  logic              bg_mode_req_i,
  input  logic              recapture_i,
  output logic              bg_we_o,
  output logic              bg_re_o,
  output logic [ADDR_W-1:0] bg_addr_o,
  output logic              use_bg_o,
  output logic              cmp_valid_o,
  output logic              bg_ready_o,
  output logic              frame_done_o,
  output logic              err_short_o,
  output logic              err_long_o,
  output seq_state_t        state_o
);

  localparam int FRAME_PIXELS = frame_pixels(FRAME_W, FRAME_H);

  // Stream protocol: a pixel is transferred in every cycle pix_valid_i is high
  // (no backpressure); pix_sof_i is meaningful only together with pix_valid_i.
  seq_state_t           state_q, cur_state;
  logic                 recap_pend_q;
  logic                 bg_ready_q;
  logic                 err_short_q;
  logic                 err_long_q;
  logic                 frame_open_q;
  logic [RD_LAT-1:0]    cmp_sr_q;

  logic                 sof;
  logic                 active;
  logic                 cap_start;
  logic                 last;
  logic                 overflow;
  logic [ADDR_W-1:0]    addr;

  assign sof = pix_valid_i & pix_sof_i;

  // Frame type is decided on the sof pixel itself so that pixel already
  // carries the new frame's RAM strobes.
  always_comb begin
    cur_state = state_q;
    if (sof) begin
      if (!bg_mode_req_i) begin
        cur_state = ST_SKIN;
      end else if (!bg_ready_q || recap_pend_q) begin
        cur_state = ST_CAPTURE;
      end else begin
        cur_state = ST_COMPARE;
      end
    end
  end

  assign active    = pix_valid_i && (cur_state != ST_IDLE);
  assign cap_start = sof && (cur_state == ST_CAPTURE);

  pix_addr_counter #(
    .ADDR_W       (ADDR_W),
    .FRAME_PIXELS (FRAME_PIXELS)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .en_i       (active),
    .sof_i      (sof),
    .addr_o     (addr),
    .last_o     (last),
    .overflow_o (overflow)
  );

  assign bg_we_o      = !rst && active && (cur_state == ST_CAPTURE) && !overflow;
  assign bg_re_o      = !rst && active && (cur_state == ST_COMPARE) && !overflow;
  assign frame_done_o = !rst && active && last;
  assign bg_addr_o    = addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      recap_pend_q <= 1'b0;
      bg_ready_q   <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
      frame_open_q <= 1'b0;
      cmp_sr_q     <= '0;
    end else begin
      state_q      <= cur_state;
      recap_pend_q <= (recap_pend_q && !cap_start) || recapture_i;
      if (cap_start) begin
        bg_ready_q <= 1'b0;
      end
      if (active && last && (cur_state == ST_CAPTURE)) begin
        bg_ready_q <= 1'b1;
      end
      if (sof && frame_open_q) begin
        err_short_q <= 1'b1;
      end
      if (active && overflow) begin
        err_long_q <= 1'b1;
      end
      if (sof) begin
        frame_open_q <= 1'b1;
      end
      if (active && last) begin
        frame_open_q <= 1'b0;
      end
      cmp_sr_q <= (cmp_sr_q << 1) | RD_LAT'(bg_re_o);
    end
  end

  assign use_bg_o    = (state_q == ST_COMPARE);
  assign cmp_valid_o = cmp_sr_q[RD_LAT-1];
  assign bg_ready_o  = bg_ready_q;
  assign err_short_o = err_short_q;
  assign err_long_o  = err_long_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_skin_frame_sequencer.sv
// Directed scoreboard bench for skin_frame_sequencer on an 8-pixel (4x2) frame.
module tb_skin_frame_sequencer;
  import skin_pkg::*;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pix_valid = 1'b0;
  logic          pix_sof = 1'b0;
  logic          mode = 1'b0;
  logic          rc = 1'b0;
  logic          bg_we, bg_re, use_bg, cmp_valid, bg_ready, frame_done;
  logic          err_short, err_long;
  logic [AW-1:0] bg_addr;
  seq_state_t    state;

  int            checks = 0;
  int            failures = 0;
  logic [7:0]    exp_q[$];
  logic          prev_re = 1'b0;
  logic          mon_en = 1'b0;
  logic [7:0]    obs;
  logic [7:0]    exp_w;

  skin_frame_sequencer #(
    .FRAME_W (4),
    .FRAME_H (2),
    .ADDR_W  (AW),
    .RD_LAT  (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pix_valid_i   (pix_valid),
    .pix_sof_i     (pix_sof),
    .bg_mode_req_i (mode),
    .recapture_i   (rc),
    .bg_we_o       (bg_we),
    .bg_re_o       (bg_re),
    .bg_addr_o     (bg_addr),
    .use_bg_o      (use_bg),
    .cmp_valid_o   (cmp_valid),
    .bg_ready_o    (bg_ready),
    .frame_done_o  (frame_done),
    .err_short_o   (err_short),
    .err_long_o    (err_long),
    .state_o       (state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Event word: {we, re, cmp_valid, cmp_valid&use_bg, frame_done, addr(if we|re)}
  task automatic pix(input logic v, input logic s, input logic e_we, input logic e_re,
                     input logic e_done, input logic [2:0] a);
    logic [7:0] w;
    logic       ec;
    pix_valid = v;
    pix_sof   = s;
    ec        = prev_re;
    prev_re   = e_re;
    w = {e_we, e_re, ec, ec, e_done, (e_we | e_re) ? a : 3'd0};
    if (e_we | e_re | ec | e_done) exp_q.push_back(w);
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    pix(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  // Monitor: pops one expected event word per cycle with any DUT event
  always @(negedge clk) begin
    if (mon_en && (bg_we || bg_re || cmp_valid || frame_done)) begin
      obs = {bg_we, bg_re, cmp_valid, cmp_valid & use_bg, frame_done,
             (bg_we | bg_re) ? bg_addr : 3'd0};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event got=%0h exp=none", obs);
      end else begin
        exp_w = exp_q.pop_front();
        chk("event", obs, exp_w);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    chk("rst_ready", {7'd0, bg_ready}, 8'd0);
    chk("rst_err_short", {7'd0, err_short}, 8'd0);
    chk("rst_err_long", {7'd0, err_long}, 8'd0);
    chk("rst_use_bg", {7'd0, use_bg}, 8'd0);
    chk("rst_state", 8'(state), 8'(ST_IDLE));

    // sof without valid, and pixel without sof, are both ignored in IDLE
    pix(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("idle_state", 8'(state), 8'(ST_IDLE));

    // Capture frame
    mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pix(1'b1, i == 0, 1'b1, 1'b0, i == 7, i[2:0]);
      if (i == 6) chk("cap_ready_pre", {7'd0, bg_ready}, 8'd0);
    end
    chk("cap_ready", {7'd0, bg_ready}, 8'd1);
    chk("cap_state", 8'(state), 8'(ST_CAPTURE));
    gap();

    // Compare frame
    for (int i = 0; i < 8; i++) pix(1'b1, i == 0, 1'b0, 1'b1, i == 7, i[2:0]);
    chk("cmp_use_bg", {7'd0, use_bg}, 8'd1);
    chk("cmp_state", 8'(state), 8'(ST_COMPARE));
    chk("cmp_err_short", {7'd0, err_short}, 8'd0);
    gap();
    gap();

    // Recapture mid-compare: current frame stays compare, next frame captures
    for (int i = 0; i < 8; i++) begin
      rc = (i == 3);
      pix(1'b1, i == 0, 1'b0, 1'b1, i == 7, i[2:0]);
    end
    rc = 1'b0;
    gap();
    chk("recap_ready_kept", {7'd0, bg_ready}, 8'd1);
    for (int i = 0; i < 8; i++) begin
      pix(1'b1, i == 0, 1'b1, 1'b0, i == 7, i[2:0]);
      if (i == 0) chk("recap_ready_drop", {7'd0, bg_ready}, 8'd0);
      if (i == 0) chk("recap_state", 8'(state), 8'(ST_CAPTURE));
      if (i == 6) chk("recap_ready_pre", {7'd0, bg_ready}, 8'd0);
    end
    chk("recap_ready_rise", {7'd0, bg_ready}, 8'd1);
    gap();

    // Short capture frame interrupted by sof after 5 pixels
    rc = 1'b1;
    gap();
    rc = 1'b0;
    for (int i = 0; i < 5; i++) pix(1'b1, i == 0, 1'b1, 1'b0, 1'b0, i[2:0]);
    chk("short_err_pre", {7'd0, err_short}, 8'd0);
    for (int i = 0; i < 8; i++) begin
      pix(1'b1, i == 0, 1'b1, 1'b0, i == 7, i[2:0]);
      if (i == 0) begin
        chk("short_err", {7'd0, err_short}, 8'd1);
        chk("short_ready", {7'd0, bg_ready}, 8'd0);
        chk("short_state", 8'(state), 8'(ST_CAPTURE));
      end
    end
    chk("short_retry_ready", {7'd0, bg_ready}, 8'd1);
    gap();

    // Long skin frame: 10 pixels without a following sof
    mode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pix(1'b1, i == 0, 1'b0, 1'b0, i == 7, 3'd0);
      if (i == 7) chk("long_err_pre", {7'd0, err_long}, 8'd0);
      if (i == 8) chk("long_err", {7'd0, err_long}, 8'd1);
    end
    chk("skin_use_bg", {7'd0, use_bg}, 8'd0);
    chk("skin_state", 8'(state), 8'(ST_SKIN));
    chk("sticky_short", {7'd0, err_short}, 8'd1);
    gap();

    // Reset at pixel 3 of a compare frame
    mode = 1'b1;
    for (int i = 0; i < 3; i++) pix(1'b1, i == 0, 1'b0, 1'b1, 1'b0, i[2:0]);
    rst = 1'b1;
    pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    rst       = 1'b0;
    pix_valid = 1'b0;
    chk("rst_mid_cmp_valid", {7'd0, cmp_valid}, 8'd0);
    chk("rst_mid_ready", {7'd0, bg_ready}, 8'd0);
    chk("rst_mid_use_bg", {7'd0, use_bg}, 8'd0);
    chk("rst_mid_err_short", {7'd0, err_short}, 8'd0);
    chk("rst_mid_err_long", {7'd0, err_long}, 8'd0);
    chk("rst_mid_state", 8'(state), 8'(ST_IDLE));
    gap();
    for (int i = 0; i < 3; i++) pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("idle_no_err", {7'd0, err_long}, 8'd0);

    // Recovery: background no longer valid, so a capture frame follows
    for (int i = 0; i < 8; i++) pix(1'b1, i == 0, 1'b1, 1'b0, i == 7, i[2:0]);
    chk("recover_ready", {7'd0, bg_ready}, 8'd1);
    gap();
    gap();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events got=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
